// File: rtl/mem_rr_arbiter_pkg.sv
// mem_rr_arbiter_pkg: shared states, default sizes and command record for mem_rr_arbiter
package mem_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_SIZE = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
  typedef struct packed {
    logic wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side and memory-side signals of the shared-memory arbiter
interface mem_rr_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic rsp_err;
  logic mem_wr;
  logic mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic mem_response;
  modport slave (
    input req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_response,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_rd, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_response,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just after last_grant
module rr_pick #(
  parameter int N = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic          any_valid,
  output logic [GW-1:0] grant
);
  // walk from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    any_valid = |req;
    grant = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last_grant) + k) % N]) grant = GW'((int'(last_grant) + k) % N);
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one single-port memory; MEM_ARB_TIMEOUT_EN adds a response watchdog
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE = DEF_MEM_SIZE
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input logic clk,
  input logic reset,
  mem_rr_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_RESP = RESP;
  logic [1:0] state;
  logic [GW-1:0] last_grant, g, pick;
  logic any_req, pick_wr, in_range, to_hit, wr_q, err_q;
  logic [ADDR_WIDTH-1:0] pick_addr, addr_q;
  logic [DATA_WIDTH-1:0] pick_wdata, wdata_q, rdata_q;
  logic [NUM_REQ-1:0] ready_q;
  rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
    .req(bus.req_valid),
    .last_grant(last_grant),
    .any_valid(any_req),
    .grant(pick)
  );
  assign pick_wr = bus.req_wr[pick];
  assign pick_addr = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_wdata = bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
  assign in_range = {1'b0, pick_addr} < (ADDR_WIDTH+1)'(MEM_SIZE);
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt;
  assign to_hit = tmo_cnt == CW'(TIMEOUT_CYCLES - 1);
  // watchdog: zero outside ISSUE so it is already cleared on entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_cnt <= '0;
    else tmo_cnt <= (state == S_ISSUE) ? tmo_cnt + 1'b1 : '0;
`else
  assign to_hit = 1'b0;
`endif
  // arbitration FSM: accept in IDLE, wait for the memory in ISSUE, report in RESP
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      g <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      ready_q <= '0;
    end else begin
      ready_q <= '0;
      if (state == S_IDLE && any_req) begin
        g <= pick;
        last_grant <= pick;
        wr_q <= pick_wr;
        addr_q <= pick_addr;
        wdata_q <= pick_wdata;
        rdata_q <= '0;
        err_q <= !in_range;
        ready_q <= NUM_REQ'(1) << pick;
        state <= in_range ? S_ISSUE : S_RESP;
      end else if (state == S_ISSUE && (bus.mem_response || to_hit)) begin
        rdata_q <= (bus.mem_response && !wr_q) ? bus.mem_rdata : '0;
        err_q <= !bus.mem_response;
        state <= S_RESP;
      end else if (state == S_RESP) begin
        state <= S_IDLE;
      end
    end
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state == S_RESP) ? NUM_REQ'(1) << g : '0;
  assign bus.rsp_rdata = (state == S_RESP) ? rdata_q : '0;
  assign bus.rsp_err = (state == S_RESP) && err_q;
  assign bus.mem_wr = (state == S_ISSUE) && wr_q;
  assign bus.mem_rd = (state == S_ISSUE) && !wr_q;
  assign bus.mem_addr = (state == S_ISSUE) ? addr_q : '0;
  assign bus.mem_wdata = (state == S_ISSUE) ? wdata_q : '0;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench for mem_rr_arbiter with a behavioural memory
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;
  typedef struct {int idx; logic [31:0] rdata; logic err;} rsp_t;
  logic clk = 0;
  logic reset = 0;
  mem_rr_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  mem_rr_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(16)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int delay = 0, dcnt = 0, resp_cyc = 0, rsp_cyc_last = 0;
  int iss_n = 0, iss_first = 0;
  bit no_resp = 0, addr_bad = 0, both_seen = 0;
  logic [7:0] iss_addr = '0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int exp_acc [$];
  rsp_t exp_rsp [$];
  cmd_t g_cmd [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // memory model: answers after `delay` command cycles unless no_resp is set
  initial begin
    bus.mem_response = 0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus.mem_response = 0;
        dcnt = 0;
      end else if ((bus.mem_wr || bus.mem_rd) && !no_resp && dcnt == delay) begin
        bus.mem_response = 1;
        if (bus.mem_wr) begin
          mem[bus.mem_addr[3:0]] = bus.mem_wdata;
          bus.mem_rdata = 32'h5555_AAAA;
        end else bus.mem_rdata = mem[bus.mem_addr[3:0]];
        resp_cyc = cyc;
        dcnt = 0;
      end else begin
        bus.mem_response = 0;
        dcnt = (bus.mem_wr || bus.mem_rd) ? dcnt + 1 : 0;
      end
    end
  end

  // monitor: pops the scoreboard on accepts and responses, tracks memory command activity
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_wr && bus.mem_rd) both_seen = 1;
      if (bus.mem_wr || bus.mem_rd) begin
        if (iss_n == 0) iss_first = cyc;
        iss_n++;
        if (bus.mem_addr !== iss_addr) addr_bad = 1;
      end
      if (bus.req_ready != 0) begin
        chk("ready_onehot", 64'($countones(bus.req_ready)), 1);
        if (exp_acc.size() == 0) chk("acc_unexpected", 64'(bus.req_ready), 0);
        else chk("acc_order", 64'(oh_idx(bus.req_ready)), 64'(exp_acc.pop_front()));
      end
      if (bus.rsp_valid != 0) begin
        rsp_t e;
        rsp_cyc_last = cyc;
        chk("rsp_onehot", 64'($countones(bus.rsp_valid)), 1);
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_idx", 64'(oh_idx(bus.rsp_valid)), 64'(e.idx));
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
    end
  end

  function automatic logic outs_any();
    return |{bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
             bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic set_cmd(input int i, input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    g_cmd[i] = '{wr: wr, addr: addr, wdata: wd};
    exp_rsp.push_back('{idx: i, rdata: (wr || addr >= 16) ? 32'h0 : ref_mem[addr[3:0]], err: addr >= 16});
    if (wr && addr < 16) ref_mem[addr[3:0]] = wd;
  endtask

  // present every requester in mask, each for `rounds` accepts, then wait for all responses
  task automatic run_group(input logic [3:0] mask, input int rounds);
    int rem [4];
    int n = 0, left;
    for (int i = 0; i < 4; i++) begin
      rem[i] = mask[i] ? rounds : 0;
      bus.req_valid[i] = mask[i];
      bus.req_wr[i] = g_cmd[i].wr;
      bus.req_addr[i*8 +: 8] = g_cmd[i].addr;
      bus.req_wdata[i*32 +: 32] = g_cmd[i].wdata;
    end
    while (n < 300) begin
      left = 0;
      for (int i = 0; i < 4; i++) left += rem[i];
      if (left == 0) break;
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) bus.req_valid[i] = 0;
        end
    end
    chk("accept_bound", 64'(n < 300), 1);
    bus.req_valid = '0;
    n = 0;
    while (exp_rsp.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 64'(exp_rsp.size()), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int k = 0; k < 16; k++) begin
      mem[k] = 32'hA000_0000 + k;
      ref_mem[k] = 32'hA000_0000 + k;
    end
    repeat (3) @(negedge clk);
    #1 chk("reset_outs", 64'(outs_any()), 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    iss_addr = 8'd5;
    exp_acc.push_back(0);
    set_cmd(0, 1, 8'd5, 32'hDEAD_BEEF);
    run_group(4'b0001, 1);
    exp_acc.push_back(0);
    set_cmd(0, 0, 8'd5, 32'h0);
    run_group(4'b0001, 1);

    do_reset();
    iss_addr = 'x;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        exp_acc.push_back(i);
        set_cmd(i, 0, 8'(i), 32'h0);
      end
    run_group(4'b1111, 2);

    iss_n = 0;
    exp_acc.push_back(2);
    set_cmd(2, 0, 8'd16, 32'h0);
    run_group(4'b0100, 1);
    chk("oor_no_mem_cmd", 64'(iss_n), 0);

    delay = 5;
    iss_n = 0;
    iss_addr = 8'd5;
    addr_bad = 0;
    exp_acc.push_back(1);
    set_cmd(1, 0, 8'd5, 32'h0);
    run_group(4'b0010, 1);
    chk("dly_cmd_cycles", 64'(iss_n), 6);
    chk("dly_addr_stable", 64'(addr_bad), 0);
    chk("dly_rsp_lat", 64'(rsp_cyc_last - resp_cyc), 1);
    delay = 0;

    no_resp = 1;
    exp_acc.push_back(3);
    bus.req_valid[3] = 1;
    bus.req_wr[3] = 0;
    bus.req_addr[24 +: 8] = 8'd3;
    n = 0;
    while (!bus.req_ready[3] && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid[3] = 0;
    n = 0;
    while (!bus.mem_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_issue", 64'(bus.mem_rd), 1);
    reset = 0;
    #1 chk("abort_outs_zero", 64'(outs_any()), 0);
    @(negedge clk);
    reset = 1;
    no_resp = 0;
    repeat (3) @(negedge clk);
    exp_acc.push_back(0);
    set_cmd(0, 0, 8'd0, 32'h0);
    exp_acc.push_back(3);
    set_cmd(3, 0, 8'd3, 32'h0);
    run_group(4'b1001, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    no_resp = 1;
    iss_n = 0;
    iss_addr = 8'd2;
    exp_acc.push_back(1);
    exp_rsp.push_back('{idx: 1, rdata: 32'h0, err: 1'b1});
    g_cmd[1] = '{wr: 1'b0, addr: 8'd2, wdata: 32'h0};
    run_group(4'b0010, 1);
    chk("tmo_latency", 64'(rsp_cyc_last - iss_first), 8);
    no_resp = 0;
    iss_addr = 8'd5;
    exp_acc.push_back(2);
    set_cmd(2, 0, 8'd5, 32'h0);
    run_group(4'b0100, 1);
`endif

    chk("wr_rd_excl", 64'(both_seen), 0);
    chk("sb_acc_empty", 64'(exp_acc.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
